uart_rx_fsm_ctrl: RTL and testbench

//  Sequencing controller for the UART receiver datapath (sampler, deserializer, parity/start/stop checkers).

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_edge_bit_cnt.sv | 25 ++
 rtl/uart_rx_fsm_ctrl.sv | 104 ++++++++++
 tb/tb_uart_rx_fsm_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, prescale constants and defaults for the UART RX controller
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int PRESC_4 = 4;
    localparam int PRESC_8 = 8;
    localparam int PRESC_16 = 16;
    localparam int DATA_WIDTH_DEF = 8;

    function automatic int presc_period(input int p);
        return (p == PRESC_4 || p == PRESC_8 || p == PRESC_16) ? p : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter and frame bit counter with wrap at p_last
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 5,
    parameter int BIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRESC_W-1:0]   p_last,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            edge_cnt <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            edge_cnt <= (edge_cnt == p_last) ? '0 : edge_cnt + 1'b1;
            bit_cnt <= (edge_cnt == p_last) ? bit_cnt + 1'b1 : bit_cnt;
        end
    end

endmodule

// File: rtl/uart_rx_fsm_ctrl.sv
// uart_rx_fsm_ctrl: UART RX frame sequencer driving sampler, deserializer and checker strobes
module uart_rx_fsm_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W = 5,
    parameter int BIT_CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic                 sampled_bit,
    input  logic                 par_err,
    input  logic                 stp_err,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 dat_samp_en,
    output logic                 strt_chk_en,
    output logic                 deser_en,
    output logic                 par_chk_en,
    output logic                 stp_chk_en,
    output logic                 data_valid
);

    state_t state;
    logic [PRESC_W-1:0] p_last;
    logic par_en_q;
    logic par_bad;
    logic run;
    logic last;
    logic cnt_clr;

    always_comb begin
        run = state inside {START, DATA, PARITY, STOP};
        last = edge_cnt == p_last;
        dat_samp_en = run;
        strt_chk_en = state == START && last;
        deser_en = state == DATA && last;
        par_chk_en = state == PARITY && last;
        stp_chk_en = state == STOP && last;
        // counters restart at 0 whenever the frame ends or the start bit proves to be a glitch
        cnt_clr = !run || (last && (state == STOP || (state == START && sampled_bit)));
    end

    uart_rx_edge_bit_cnt #(
        .PRESC_W(PRESC_W),
        .BIT_CNT_W(BIT_CNT_W)
    ) u_cnt (
        .clk(CLK),
        .rst_n(RST),
        .en(run),
        .clr(cnt_clr),
        .p_last(p_last),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            p_last <= '0;
            par_en_q <= 1'b0;
            par_bad <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state <= START;
                        p_last <= PRESC_W'(presc_period(int'(prescale)) - 1);
                        par_en_q <= PAR_EN;
                    end
                end
                START: if (last) state <= sampled_bit ? IDLE : DATA;
                DATA: if (last && bit_cnt == BIT_CNT_W'(DATA_WIDTH)) state <= par_en_q ? PARITY : STOP;
                PARITY: begin
                    if (last) begin
                        par_bad <= par_bad | par_err;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (last) begin
                        state <= DONE;
                        data_valid <= !par_bad && !stp_err;
                    end
                end
                DONE: begin
                    par_bad <= 1'b0;
                    state <= RX_IN ? IDLE : START;
                    if (!RX_IN) begin
                        p_last <= PRESC_W'(presc_period(int'(prescale)) - 1);
                        par_en_q <= PAR_EN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// tb_uart_rx_fsm_ctrl: directed and random frames checked cycle by cycle against a frame-timing model
module tb_uart_rx_fsm_ctrl;

    logic clk = 1'b0;
    logic RST, RX_IN, PAR_EN, sampled_bit, par_err, stp_err;
    logic [4:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int dv_q[$];

    uart_rx_fsm_ctrl dut (
        .CLK(clk),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .prescale(prescale),
        .sampled_bit(sampled_bit),
        .par_err(par_err),
        .stp_err(stp_err),
        .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .deser_en(deser_en),
        .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (data_valid === 1'b1) dv_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_edge"}, 32'(edge_cnt), 0);
        chk({tag, "_bit"}, 32'(bit_cnt), 0);
        chk({tag, "_strobes"}, 32'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
        chk({tag, "_dv"}, 32'(data_valid), 0);
    endtask

    task automatic idle(input int k);
        RX_IN = 1'b1;
        repeat (k) begin
            @(negedge clk);
            chk_all_zero("idle");
        end
    endtask

    // Called in the cycle before the start edge t0; value checked at loop step n is the one seen at edge t0+n.
    task automatic frame(input int pcfg, input bit par, input logic [7:0] d, input bit par_ok,
                         input bit stop, input bit glitch, input bit b2b, input int abort_n);
        int p, f, idx;
        logic [10:0] bits;
        bit ok;
        p = (pcfg == 4 || pcfg == 8 || pcfg == 16) ? pcfg : 8;
        f = glitch ? p : (10 + int'(par)) * p;
        bits = '1;
        bits[0] = glitch;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
        if (par) bits[9] = (^d) ^ !par_ok;
        bits[9 + int'(par)] = stop;
        ok = !glitch && stop && (!par || par_ok);
        RX_IN = 1'b0;
        prescale = 5'(pcfg);
        PAR_EN = par;
        sampled_bit = 1'($urandom);
        par_err = 1'($urandom);
        stp_err = 1'($urandom);
        for (int n = 1; n <= f + 1; n++) begin
            @(negedge clk);
            if (n <= f) begin
                chk("edge_cnt", 32'(edge_cnt), 32'((n - 1) % p));
                chk("bit_cnt", 32'(bit_cnt), 32'((n - 1) / p));
            end
            chk("dat_samp_en", 32'(dat_samp_en), 32'(n <= f));
            chk("strt_chk_en", 32'(strt_chk_en), 32'(n == p));
            chk("deser_en", 32'(deser_en), 32'(!glitch && n % p == 0 && n / p >= 2 && n / p <= 9));
            chk("par_chk_en", 32'(par_chk_en), 32'(!glitch && par && n == 10 * p));
            chk("stp_chk_en", 32'(stp_chk_en), 32'(!glitch && n == f));
            chk("data_valid", 32'(data_valid), 32'(ok && n == f + 1));
            if (n == abort_n) begin
                RST = 1'b0;
                RX_IN = 1'b1;
                @(negedge clk);
                chk_all_zero("abort");
                RST = 1'b1;
                idle(2);
                return;
            end
            if (n <= f) begin
                idx = (n - 1) / p;
                RX_IN = glitch ? (n >= 2) : bits[idx];
                sampled_bit = bits[idx];
                par_err = (par && idx == 9) ? bits[9] ^ (^d) : 1'($urandom);
                stp_err = (idx == 9 + int'(par)) ? !bits[idx] : 1'($urandom);
                prescale = 5'($urandom);
                PAR_EN = 1'($urandom);
            end else begin
                RX_IN = !b2b;
            end
        end
        if (!b2b) idle(2);
    endtask

    initial begin
        int pc, sel;
        bit b2b;
        RST = 1'b0;
        RX_IN = 1'b0;
        PAR_EN = 1'b1;
        prescale = 5'd8;
        sampled_bit = 1'b0;
        par_err = 1'b1;
        stp_err = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        RST = 1'b1;
        idle(3);
        frame(8, 1'b1, 8'h46, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        frame(8, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        frame(8, 1'b1, 8'h46, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        frame(4, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        dv_q.delete();
        frame(4, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        frame(4, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("b2b_count", 32'(dv_q.size()), 2);
        if (dv_q.size() == 2) chk("b2b_spacing", 32'(dv_q[1] - dv_q[0]), 45);
        frame(8, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 4 * 8 + 3);
        frame(5, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        frame(16, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        b2b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 3));
            pc = (sel == 0) ? 4 : (sel == 1) ? 8 : (sel == 2) ? 16 : int'($urandom_range(0, 31));
            if (!b2b) idle(int'($urandom_range(0, 3)));
            b2b = (i != 23) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0)
                b2b = 1'b0;
            if (!b2b && $urandom_range(0, 7) == 0)
                frame(pc, 1'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 0);
            else
                frame(pc, 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0, 1'b0, b2b, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
